// File: rtl/flatten_seq_ctrl_if.sv
// Stream-in / vector-out bundle between a layer's serial output port,
// the flatten sequencer and the next dense layer's flattened input bus.
interface flatten_seq_ctrl_if #(
  parameter int bits = 18,
  parameter int size = 784
) ();
  localparam int CW = $clog2(size + 1);

  logic                   start;
  logic                   in_valid;
  logic [bits-1:0]        in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [bits*size-1:0]   flattened_array_out;
  logic                   done;
  logic                   busy;
  logic [CW-1:0]          elem_count;

  // Environment side: producer, consumer and sequencing control.
  modport master (
    output start,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  flattened_array_out,
    input  done,
    input  busy,
    input  elem_count
  );

  // Controller side.
  modport slave (
    input  start,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output flattened_array_out,
    output done,
    output busy,
    output elem_count
  );
endinterface

// File: rtl/flatten_seq_ctrl.sv
// Flatten sequencer: collects `size` serial elements into one packed,
// LSB-first vector and holds it until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for start; last vector stays visible on the bus
//   FILL  | accepting one element per valid beat, in_ready high
//   HOLD  | vector complete, out_valid high until out_ready
module flatten_seq_ctrl #(
  parameter int bits = 18,
  parameter int size = 784
) (
  input  logic             clk,
  input  logic             rst,
  flatten_seq_ctrl_if.slave s
);
  localparam int CW = $clog2(size + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [bits*size-1:0]  r_buf;
  logic [CW-1:0]         r_count;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_in_ready;

  assign w_in_ready = (r_state == S_FILL);
  assign w_accept   = s.in_valid && w_in_ready;
  assign w_last     = (r_count == CW'(size - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode; start is only honoured in IDLE or when HOLD releases.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (s.start) w_next_state = S_FILL;
      S_FILL: if (w_accept && w_last) w_next_state = S_HOLD;
      S_HOLD: if (s.out_ready) w_next_state = s.start ? S_FILL : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Packing buffer and element counter; buffer is kept on HOLD->IDLE so the
  // last vector stays readable, and cleared whenever a new vector begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s.start) begin
            r_buf   <= '0;
            r_count <= '0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_buf[r_count*bits +: bits] <= s.in_data;
            r_count                     <= r_count + CW'(1);
          end
        end
        S_HOLD: begin
          if (s.out_ready) begin
            r_count <= '0;
            if (s.start) r_buf <= '0;
          end
        end
        default: begin
          r_buf   <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

  // Completion pulse: registered off the accepting edge so it lines up with
  // the first HOLD cycle only.
  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= (r_state == S_FILL) && w_accept && w_last;
  end

  // Handshake outputs decoded from state.
  always_comb begin
    s.in_ready  = w_in_ready;
    s.out_valid = (r_state == S_HOLD);
    s.busy      = (r_state == S_FILL) || (r_state == S_HOLD);
  end

  assign s.done                = r_done;
  assign s.flattened_array_out = r_buf;
  assign s.elem_count          = r_count;
endmodule

// File: tb/tb_flatten_seq_ctrl.sv
module tb_flatten_seq_ctrl;
  logic clk;
  logic rst;
  logic rst_big;
  int   n_checks;
  int   n_errors;

  flatten_seq_ctrl_if #(.bits(4), .size(4)) sif ();
  flatten_seq_ctrl_if #(.bits(18), .size(784)) bif ();

  flatten_seq_ctrl #(.bits(4), .size(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .s   (sif.slave)
  );

  flatten_seq_ctrl #(.bits(18), .size(784)) dut_big (
    .clk (clk),
    .rst (rst_big),
    .s   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every small-DUT output against a full expected snapshot.
  task automatic chk_all(input string tag, input logic rdy, input logic ov,
                         input logic dn, input logic bsy, input logic [2:0] cnt,
                         input logic [15:0] vec);
    chk({tag, ".in_ready"},  {63'd0, sif.in_ready},  {63'd0, rdy});
    chk({tag, ".out_valid"}, {63'd0, sif.out_valid}, {63'd0, ov});
    chk({tag, ".done"},      {63'd0, sif.done},      {63'd0, dn});
    chk({tag, ".busy"},      {63'd0, sif.busy},      {63'd0, bsy});
    chk({tag, ".count"},     {61'd0, sif.elem_count}, {61'd0, cnt});
    chk({tag, ".vec"},       {48'd0, sif.flattened_array_out}, {48'd0, vec});
  endtask

  task automatic push(input logic [3:0] d);
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    tick();
  endtask

  initial begin
    logic [3:0] bub_v [7];
    logic [3:0] bub_d [7];
    int cyc;
    int k;
    n_checks = 0;
    n_errors = 0;
    sif.start = 1'b1; sif.in_valid = 1'b1; sif.in_data = 4'h7; sif.out_ready = 1'b0;
    bif.start = 1'b0; bif.in_valid = 1'b0; bif.in_data = '0;   bif.out_ready = 1'b0;
    rst = 1'b1; rst_big = 1'b1;

    // Reset with start and in_valid asserted.
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0, 3'd0, 16'h0000);
    rst = 1'b0; sif.start = 1'b0; sif.in_valid = 1'b0;
    tick();
    chk_all("idle", 0, 0, 0, 0, 3'd0, 16'h0000);

    // Basic fill 1,2,3,F.
    sif.start = 1'b1; tick(); sif.start = 1'b0;
    chk_all("fill0", 1, 0, 0, 1, 3'd0, 16'h0000);
    push(4'h1); chk_all("fill1", 1, 0, 0, 1, 3'd1, 16'h0001);
    push(4'h2); chk_all("fill2", 1, 0, 0, 1, 3'd2, 16'h0021);
    push(4'h3); chk_all("fill3", 1, 0, 0, 1, 3'd3, 16'h0321);
    push(4'hF); chk_all("hold0", 0, 1, 1, 1, 3'd4, 16'hF321);
    sif.in_valid = 1'b0; tick();
    chk_all("hold1", 0, 1, 0, 1, 3'd4, 16'hF321);
    sif.out_ready = 1'b1; tick(); sif.out_ready = 1'b0;
    chk_all("release", 0, 0, 0, 0, 3'd0, 16'hF321);

    // Bubbles 5,_,6,_,_,7,8 with a stray start mid-fill.
    bub_v = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1};
    bub_d = '{4'h5, 4'h9, 4'h6, 4'h9, 4'h9, 4'h7, 4'h8};
    sif.start = 1'b1; tick(); sif.start = 1'b0;
    chk_all("bub.start", 1, 0, 0, 1, 3'd0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      sif.in_valid = bub_v[i][0];
      sif.in_data  = bub_d[i];
      sif.start    = (i == 3);
      tick();
    end
    sif.start = 1'b0;
    chk_all("bub.pre", 1, 0, 0, 1, 3'd3, 16'h0765);
    sif.in_valid = 1'b1; sif.in_data = bub_d[6]; tick();
    chk_all("bub.hold", 0, 1, 1, 1, 3'd4, 16'h8765);
    // Backpressure with an element offered while holding.
    sif.in_data = 4'h9;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("bub.bp", 0, 1, 0, 1, 3'd4, 16'h8765);
    end
    sif.in_valid = 1'b0; sif.out_ready = 1'b1; tick(); sif.out_ready = 1'b0;
    chk_all("bub.idle", 0, 0, 0, 0, 3'd0, 16'h8765);

    // in_valid while idle is ignored.
    sif.in_valid = 1'b1; sif.in_data = 4'h3; tick(); tick();
    chk_all("idle.iv", 0, 0, 0, 0, 3'd0, 16'h8765);
    sif.in_valid = 1'b0;

    // Back-to-back: release HOLD with start in the same cycle.
    sif.start = 1'b1; tick(); sif.start = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    chk_all("b2b.hold", 0, 1, 1, 1, 3'd4, 16'h4321);
    sif.in_valid = 1'b0; sif.out_ready = 1'b1; sif.start = 1'b1; tick();
    sif.out_ready = 1'b0; sif.start = 1'b0;
    chk_all("b2b.fill", 1, 0, 0, 1, 3'd0, 16'h0000);
    push(4'hA); push(4'hB); push(4'hC); push(4'hD);
    chk_all("b2b.vec", 0, 1, 1, 1, 3'd4, 16'hDCBA);
    sif.in_valid = 1'b0; sif.out_ready = 1'b1; tick(); sif.out_ready = 1'b0;

    // Reset after two elements.
    sif.start = 1'b1; tick(); sif.start = 1'b0;
    push(4'h6); push(4'h7);
    chk_all("mid.pre", 1, 0, 0, 1, 3'd2, 16'h0076);
    sif.in_valid = 1'b1; sif.in_data = 4'h5; rst = 1'b1; tick(); rst = 1'b0;
    sif.in_valid = 1'b0;
    chk_all("mid.rst", 0, 0, 0, 0, 3'd0, 16'h0000);

    // Default parameters: stream 0..783 and time the done pulse from start.
    rst_big = 1'b0; tick();
    bif.start = 1'b1; tick(); bif.start = 1'b0;
    cyc = 1;
    k = 0;
    while (!bif.done && cyc < 1000) begin
      bif.in_valid = (k < 784);
      bif.in_data  = 18'(k);
      tick();
      cyc++;
      if (k < 784) k++;
    end
    bif.in_valid = 1'b0;
    chk("big.latency", 64'(cyc), 64'd785);
    chk("big.count", 64'(bif.elem_count), 64'd784);
    chk("big.out_valid", {63'd0, bif.out_valid}, 64'd1);
    for (int i = 0; i < 784; i++) begin
      chk("big.slice", {46'd0, bif.flattened_array_out[i*18 +: 18]}, 64'(i));
    end
    tick();
    chk("big.done_once", {63'd0, bif.done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
